// File: rtl/ifu_prefetch_pkg.sv
// ----------------------------------------------------------------------------
// ifu_prefetch_pkg
// Shared definitions for the instruction-fetch prefetch unit: default
// bus widths, the default reset fetch address, the instruction size in
// bytes, and a helper that gives the width of one packed {pc, inst} entry.
// ----------------------------------------------------------------------------
package ifu_prefetch_pkg;

    localparam int unsigned INST_ADDR_W   = 32;            // InstAddrBus width
    localparam int unsigned INST_DATA_W   = 32;            // InstBus width
    localparam int unsigned PREFETCH_DEPTH = 4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam int unsigned INST_BYTES    = 4;

    // Width of one prefetch entry: {pc, inst}.
    function automatic int unsigned fetch_entry_w(input int unsigned addr_w,
                                                  input int unsigned data_w);
        return addr_w + data_w;
    endfunction

endpackage

// File: rtl/ifu_prefetch_sync_fifo.sv
// ----------------------------------------------------------------------------
// ifu_prefetch_sync_fifo
// Synchronous FIFO holding packed {pc, inst} fetch entries.
// Ports:
//   clk, rst            clock, synchronous active-low reset
//   push_i/push_data_i  write one entry (caller guarantees not full)
//   pop_i               drop the head entry
//   clear_i             empty the FIFO (highest priority)
//   clear_keep_one_i    keep only the entry after the head, as the new head
//   head_data_o         current head entry
//   count_o             number of stored entries
//   empty_o             no entries stored
// Pointers carry one extra wrap bit so full and empty are distinguishable.
// ----------------------------------------------------------------------------
module ifu_prefetch_sync_fifo #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic [DATA_W-1:0]        push_data_i,
    input  logic                     pop_i,
    input  logic                     clear_i,
    input  logic                     clear_keep_one_i,
    output logic [DATA_W-1:0]        head_data_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     empty_o
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned PTR_W = IDX_W + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic              wr_en;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        wr_en    = 1'b0;
        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else if (clear_keep_one_i) begin
            // Entry rd+1 becomes the sole entry; everything after it is gone.
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
            wr_ptr_d = rd_ptr_q + PTR_W'(2);
        end else begin
            if (push_i) begin
                wr_en    = 1'b1;
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop_i) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: it is only visible through a valid head.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q[IDX_W-1:0]] <= push_data_i;
        end
    end

    assign head_data_o = mem_q[rd_ptr_q[IDX_W-1:0]];
    assign count_o     = wr_ptr_q - rd_ptr_q;
    assign empty_o     = (wr_ptr_q == rd_ptr_q);

endmodule

// File: rtl/ifu_prefetch.sv
// ----------------------------------------------------------------------------
// ifu_prefetch
// Instruction fetch unit with a prefetch FIFO of {pc, inst} pairs between the
// instruction ROM and the decode stage. One ROM request may be outstanding.
// Ports:
//   clk, rst                 clock, synchronous active-low reset
//   rom_req_o/rom_addr_o     fetch request and its address
//   rom_ack_i                request accepted this cycle
//   rom_rvalid_i/rom_data_i  read response, in request order
//   id_valid_o/id_pc_o/id_inst_o  head entry towards decode
//   id_ready_i               decode consumes the head
//   branch_flag_i/branch_target_address_i  taken branch decoded on the head
//   flush_i/flush_pc_i       full pipeline flush and restart address
//   busy_o                   a request is outstanding
// ROM handshake: a request transfers when rom_req_o & rom_ack_i at a rising
// edge; rom_addr_o holds until then. A response transfers on rom_rvalid_i and
// belongs to the oldest outstanding request (or to a request accepted in the
// same cycle). Decode handshake: the head transfers on id_valid_o & id_ready_i.
// ----------------------------------------------------------------------------
module ifu_prefetch
    import ifu_prefetch_pkg::*;
#(
    parameter int unsigned       ADDR_W   = INST_ADDR_W,
    parameter int unsigned       DATA_W   = INST_DATA_W,
    parameter int unsigned       DEPTH    = PREFETCH_DEPTH,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC)
) (
    input  logic              clk,
    input  logic              rst,
    output logic              rom_req_o,
    output logic [ADDR_W-1:0] rom_addr_o,
    input  logic              rom_ack_i,
    input  logic              rom_rvalid_i,
    input  logic [DATA_W-1:0] rom_data_i,
    output logic              id_valid_o,
    output logic [ADDR_W-1:0] id_pc_o,
    output logic [DATA_W-1:0] id_inst_o,
    input  logic              id_ready_i,
    input  logic              branch_flag_i,
    input  logic [ADDR_W-1:0] branch_target_address_i,
    input  logic              flush_i,
    input  logic [ADDR_W-1:0] flush_pc_i,
    output logic              busy_o
);

    localparam int unsigned       ENTRY_W   = fetch_entry_w(ADDR_W, DATA_W);
    localparam int unsigned       CNT_W     = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0]  DEPTH_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0]  TWO_CNT   = CNT_W'(2);
    localparam logic [ADDR_W-1:0] PC_STEP   = ADDR_W'(INST_BYTES);

    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0] req_addr_q, req_addr_d;
    logic [ADDR_W-1:0] redirect_pc_q, redirect_pc_d;
    logic              outstanding_q, outstanding_d;
    logic              drop_q, drop_d;
    logic              redirect_pend_q, redirect_pend_d;

    logic              req_fire, resp_fire, pop_fire, br_fire, br_multi;
    logic [ADDR_W-1:0] resp_addr;
    logic              fifo_push, fifo_pop, fifo_clear, fifo_keep_one;
    logic [ENTRY_W-1:0] fifo_head;
    logic [CNT_W-1:0]  fifo_count;
    logic              fifo_empty;

    assign rom_req_o  = rst & ~outstanding_q
                      & ((fifo_count + CNT_W'(outstanding_q)) < DEPTH_CNT);
    assign rom_addr_o = fetch_pc_q;
    assign busy_o     = outstanding_q;
    assign id_valid_o = ~fifo_empty;
    assign id_pc_o    = id_valid_o ? fifo_head[ENTRY_W-1:DATA_W] : '0;
    assign id_inst_o  = id_valid_o ? fifo_head[DATA_W-1:0] : '0;

    always_comb begin
        req_fire  = rom_req_o & rom_ack_i;
        // A response may also return in the same cycle its request is accepted.
        resp_fire = rom_rvalid_i & (outstanding_q | req_fire);
        resp_addr = outstanding_q ? req_addr_q : fetch_pc_q;
        pop_fire  = id_valid_o & id_ready_i;
        br_fire   = branch_flag_i & pop_fire & ~flush_i;
        br_multi  = br_fire & (fifo_count >= TWO_CNT);

        fetch_pc_d      = fetch_pc_q;
        req_addr_d      = req_addr_q;
        redirect_pc_d   = redirect_pc_q;
        outstanding_d   = outstanding_q;
        drop_d          = drop_q;
        redirect_pend_d = redirect_pend_q;
        fifo_push       = resp_fire & ~(outstanding_q & drop_q);
        fifo_pop        = pop_fire;
        fifo_clear      = 1'b0;
        fifo_keep_one   = 1'b0;

        if (req_fire) begin
            outstanding_d = 1'b1;
            req_addr_d    = fetch_pc_q;
            if (redirect_pend_q) begin
                fetch_pc_d      = redirect_pc_q;
                redirect_pend_d = 1'b0;
            end else begin
                fetch_pc_d = fetch_pc_q + PC_STEP;
            end
        end
        if (resp_fire) begin
            outstanding_d = 1'b0;
            drop_d        = 1'b0;
        end

        // Whatever is still in flight after this edge belongs to the old
        // stream on a flush or multi-entry branch, so it must be discarded.
        if (flush_i) begin
            fifo_clear      = 1'b1;
            fifo_push       = 1'b0;
            fifo_pop        = 1'b0;
            fetch_pc_d      = flush_pc_i;
            redirect_pend_d = 1'b0;
            drop_d          = outstanding_d;
        end else if (br_multi) begin
            // Delay slot is already buffered as entry 1; keep only it.
            fifo_keep_one   = 1'b1;
            fifo_push       = 1'b0;
            fifo_pop        = 1'b0;
            fetch_pc_d      = branch_target_address_i;
            redirect_pend_d = 1'b0;
            drop_d          = outstanding_d;
        end else if (br_fire) begin
            if (outstanding_q | req_fire) begin
                // Delay slot is in flight (or being requested now): keep it.
                fetch_pc_d = branch_target_address_i;
            end else begin
                // Delay slot not yet requested: fetch it first, then target.
                redirect_pend_d = 1'b1;
                redirect_pc_d   = branch_target_address_i;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            fetch_pc_q      <= RESET_PC;
            req_addr_q      <= '0;
            redirect_pc_q   <= '0;
            outstanding_q   <= 1'b0;
            drop_q          <= 1'b0;
            redirect_pend_q <= 1'b0;
        end else begin
            fetch_pc_q      <= fetch_pc_d;
            req_addr_q      <= req_addr_d;
            redirect_pc_q   <= redirect_pc_d;
            outstanding_q   <= outstanding_d;
            drop_q          <= drop_d;
            redirect_pend_q <= redirect_pend_d;
        end
    end

    ifu_prefetch_sync_fifo #(
        .DATA_W (ENTRY_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk              (clk),
        .rst              (rst),
        .push_i           (fifo_push),
        .push_data_i      ({resp_addr, rom_data_i}),
        .pop_i            (fifo_pop),
        .clear_i          (fifo_clear),
        .clear_keep_one_i (fifo_keep_one),
        .head_data_o      (fifo_head),
        .count_o          (fifo_count),
        .empty_o          (fifo_empty)
    );

endmodule

// File: tb/tb_ifu_prefetch.sv
module tb_ifu_prefetch;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              rom_req_o;
    logic [ADDR_W-1:0] rom_addr_o;
    logic              rom_ack_i;
    logic              rom_rvalid_i;
    logic [DATA_W-1:0] rom_data_i;
    logic              id_valid_o;
    logic [ADDR_W-1:0] id_pc_o;
    logic [DATA_W-1:0] id_inst_o;
    logic              id_ready_i;
    logic              branch_flag_i;
    logic [ADDR_W-1:0] branch_target_address_i;
    logic              flush_i;
    logic [ADDR_W-1:0] flush_pc_i;
    logic              busy_o;

    always #5 clk = ~clk;

    ifu_prefetch #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .DEPTH    (DEPTH),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk                     (clk),
        .rst                     (rst),
        .rom_req_o               (rom_req_o),
        .rom_addr_o              (rom_addr_o),
        .rom_ack_i               (rom_ack_i),
        .rom_rvalid_i            (rom_rvalid_i),
        .rom_data_i              (rom_data_i),
        .id_valid_o              (id_valid_o),
        .id_pc_o                 (id_pc_o),
        .id_inst_o               (id_inst_o),
        .id_ready_i              (id_ready_i),
        .branch_flag_i           (branch_flag_i),
        .branch_target_address_i (branch_target_address_i),
        .flush_i                 (flush_i),
        .flush_pc_i              (flush_pc_i),
        .busy_o                  (busy_o)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // ROM responder state: one request in flight, optional extra delay.
    logic        pend;
    logic [31:0] pend_addr;
    int unsigned rom_hold;

    logic [31:0] exp_q[$];

    typedef struct {
        logic        rst;
        logic        ack;
        logic        rvalid;
        logic [31:0] data;
        logic        ready;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_pc;
        logic [31:0] e_inst;
        logic        e_busy;
    } vec_t;

    vec_t vecs[10];

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        return {16'hC0DE, a[15:0]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_head(input string name, input logic [31:0] pc);
        chk({name, ".valid"}, {31'd0, id_valid_o}, 32'd1);
        chk({name, ".pc"}, id_pc_o, pc);
        chk({name, ".inst"}, id_inst_o, rom_word(pc));
    endtask

    task automatic do_reset();
        rst = 1'b0;
        rom_ack_i = 1'b0;
        rom_rvalid_i = 1'b0;
        rom_data_i = '0;
        id_ready_i = 1'b0;
        branch_flag_i = 1'b0;
        branch_target_address_i = '0;
        flush_i = 1'b0;
        flush_pc_i = '0;
        pend = 1'b0;
        pend_addr = '0;
        rom_hold = 0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    // Called at the negedge; advances to just after the next posedge and
    // drives the ROM response for the request accepted at that edge.
    task automatic next_cycle();
        logic        fire;
        logic [31:0] a;
        fire = rom_req_o && rom_ack_i;
        a    = rom_addr_o;
        if (rom_rvalid_i) pend = 1'b0;
        if (fire) begin
            pend = 1'b1;
            pend_addr = a;
        end
        @(posedge clk);
        #1;
        rom_rvalid_i = pend && (rom_hold == 0);
        rom_data_i = rom_rvalid_i ? rom_word(pend_addr) : '0;
        if (rom_hold > 0) rom_hold--;
        branch_flag_i = 1'b0;
        flush_i = 1'b0;
    endtask

    initial begin
        // {rst, ack, rvalid, data, ready, e_req, e_addr, e_valid, e_pc, e_inst, e_busy}
        vecs[0] = '{1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 1'b0, 32'h00, 1'b0, 32'h0, 32'h0,         1'b0};
        vecs[1] = '{1'b1, 1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 32'h00, 1'b0, 32'h0, 32'h0,         1'b0};
        vecs[2] = '{1'b1, 1'b1, 1'b1, 32'hC0DE_0000, 1'b1, 1'b0, 32'h04, 1'b0, 32'h0, 32'h0,         1'b1};
        vecs[3] = '{1'b1, 1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 32'h04, 1'b1, 32'h0, 32'hC0DE_0000, 1'b0};
        vecs[4] = '{1'b1, 1'b1, 1'b1, 32'hC0DE_0004, 1'b1, 1'b0, 32'h08, 1'b0, 32'h0, 32'h0,         1'b1};
        vecs[5] = '{1'b1, 1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 32'h08, 1'b1, 32'h4, 32'hC0DE_0004, 1'b0};
        vecs[6] = '{1'b1, 1'b1, 1'b1, 32'hC0DE_0008, 1'b1, 1'b0, 32'h0C, 1'b0, 32'h0, 32'h0,         1'b1};
        vecs[7] = '{1'b1, 1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 32'h0C, 1'b1, 32'h8, 32'hC0DE_0008, 1'b0};
        vecs[8] = '{1'b1, 1'b1, 1'b1, 32'hC0DE_000C, 1'b1, 1'b0, 32'h10, 1'b0, 32'h0, 32'h0,         1'b1};
        vecs[9] = '{1'b1, 1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 32'h10, 1'b1, 32'hC, 32'hC0DE_000C, 1'b0};

        // Reset and free-running fetch, one cycle ROM latency.
        do_reset();
        for (int i = 0; i < 10; i++) begin
            rst = vecs[i].rst;
            rom_ack_i = vecs[i].ack;
            rom_rvalid_i = vecs[i].rvalid;
            rom_data_i = vecs[i].data;
            id_ready_i = vecs[i].ready;
            @(negedge clk);
            chk($sformatf("v%0d.req", i), {31'd0, rom_req_o}, {31'd0, vecs[i].e_req});
            chk($sformatf("v%0d.addr", i), rom_addr_o, vecs[i].e_addr);
            chk($sformatf("v%0d.valid", i), {31'd0, id_valid_o}, {31'd0, vecs[i].e_valid});
            chk($sformatf("v%0d.pc", i), id_pc_o, vecs[i].e_pc);
            chk($sformatf("v%0d.inst", i), id_inst_o, vecs[i].e_inst);
            chk($sformatf("v%0d.busy", i), {31'd0, busy_o}, {31'd0, vecs[i].e_busy});
            @(posedge clk);
            #1;
        end

        // Zero-latency response: ack and rvalid with the request.
        do_reset();
        rst = 1'b1; rom_ack_i = 1'b1; rom_rvalid_i = 1'b1; rom_data_i = 32'hDEAD_0000;
        @(posedge clk);
        #1;
        rom_ack_i = 1'b0; rom_rvalid_i = 1'b0;
        @(negedge clk);
        chk("zl.valid", {31'd0, id_valid_o}, 32'd1);
        chk("zl.pc", id_pc_o, 32'h0);
        chk("zl.inst", id_inst_o, 32'hDEAD_0000);
        chk("zl.busy", {31'd0, busy_o}, 32'd0);
        chk("zl.addr", rom_addr_o, 32'h4);

        // Decode stalled: FIFO fills to DEPTH, then drains back-to-back.
        do_reset();
        rst = 1'b1; rom_ack_i = 1'b1; id_ready_i = 1'b0;
        repeat (10) begin
            @(negedge clk);
            next_cycle();
        end
        exp_q = {32'h0, 32'h4, 32'h8, 32'hC, 32'h10};
        id_ready_i = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (k == 0) begin
                chk("stall.req", {31'd0, rom_req_o}, 32'd0);
                chk("stall.busy", {31'd0, busy_o}, 32'd0);
            end
            chk_head($sformatf("drain%0d", k), exp_q.pop_front());
            next_cycle();
        end

        // Branch with FIFO {0x10,0x14,0x18} and 0x1C in flight.
        do_reset();
        rst = 1'b1; rom_ack_i = 1'b0; flush_i = 1'b1; flush_pc_i = 32'h10;
        @(negedge clk);
        next_cycle();
        rom_ack_i = 1'b1;
        repeat (6) begin
            @(negedge clk);
            next_cycle();
        end
        rom_hold = 3;
        @(negedge clk);
        chk_head("bra.pre", 32'h10);
        chk("bra.req", {31'd0, rom_req_o}, 32'd1);
        chk("bra.addr", rom_addr_o, 32'h1C);
        next_cycle();
        id_ready_i = 1'b1; branch_flag_i = 1'b1; branch_target_address_i = 32'h100;
        @(negedge clk);
        chk("bra.busy", {31'd0, busy_o}, 32'd1);
        chk_head("bra.br", 32'h10);
        next_cycle();
        id_ready_i = 1'b0;
        @(negedge clk);
        chk_head("bra.slot", 32'h14);
        chk("bra.busy2", {31'd0, busy_o}, 32'd1);
        next_cycle();
        repeat (5) begin
            @(negedge clk);
            next_cycle();
        end
        id_ready_i = 1'b1;
        @(negedge clk);
        chk_head("bra.h0", 32'h14);
        next_cycle();
        @(negedge clk);
        chk_head("bra.h1", 32'h100);
        next_cycle();
        @(negedge clk);
        chk_head("bra.h2", 32'h104);

        // Branch with a single buffered entry and nothing in flight.
        do_reset();
        rst = 1'b1; rom_ack_i = 1'b0; flush_i = 1'b1; flush_pc_i = 32'h20;
        @(negedge clk);
        next_cycle();
        rom_ack_i = 1'b1;
        @(negedge clk);
        chk("brc.addr0", rom_addr_o, 32'h20);
        next_cycle();
        rom_ack_i = 1'b0;
        @(negedge clk);
        next_cycle();
        id_ready_i = 1'b1; branch_flag_i = 1'b1; branch_target_address_i = 32'h200;
        @(negedge clk);
        chk_head("brc.br", 32'h20);
        chk("brc.addr1", rom_addr_o, 32'h24);
        chk("brc.busy", {31'd0, busy_o}, 32'd0);
        next_cycle();
        rom_ack_i = 1'b1;
        @(negedge clk);
        chk("brc.empty", {31'd0, id_valid_o}, 32'd0);
        chk("brc.req", {31'd0, rom_req_o}, 32'd1);
        chk("brc.addr2", rom_addr_o, 32'h24);
        next_cycle();
        @(negedge clk);
        chk("brc.addr3", rom_addr_o, 32'h200);
        chk("brc.busy2", {31'd0, busy_o}, 32'd1);
        next_cycle();
        @(negedge clk);
        chk_head("brc.h0", 32'h24);
        next_cycle();
        @(negedge clk);
        next_cycle();
        @(negedge clk);
        chk_head("brc.h1", 32'h200);

        // Flush while a response arrives.
        do_reset();
        rst = 1'b1; rom_ack_i = 1'b1; id_ready_i = 1'b0;
        @(negedge clk);
        next_cycle();
        flush_i = 1'b1; flush_pc_i = 32'h180;
        @(negedge clk);
        chk("fl.busy", {31'd0, busy_o}, 32'd1);
        next_cycle();
        @(negedge clk);
        chk("fl.valid", {31'd0, id_valid_o}, 32'd0);
        chk("fl.addr", rom_addr_o, 32'h180);
        chk("fl.busy2", {31'd0, busy_o}, 32'd0);
        next_cycle();
        @(negedge clk);
        next_cycle();
        @(negedge clk);
        chk_head("fl.h0", 32'h180);

        // Ack withheld, reset pulsed mid-wait, stale response afterwards.
        do_reset();
        rst = 1'b1; rom_ack_i = 1'b0; flush_i = 1'b1; flush_pc_i = 32'h40;
        @(negedge clk);
        next_cycle();
        @(negedge clk);
        chk("rs.req0", {31'd0, rom_req_o}, 32'd1);
        chk("rs.addr0", rom_addr_o, 32'h40);
        next_cycle();
        @(negedge clk);
        chk("rs.addr1", rom_addr_o, 32'h40);
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        chk("rs.req_rst", {31'd0, rom_req_o}, 32'd0);
        next_cycle();
        rst = 1'b1; rom_rvalid_i = 1'b1; rom_data_i = 32'hBAD0_BAD0;
        @(negedge clk);
        chk("rs.req1", {31'd0, rom_req_o}, 32'd1);
        chk("rs.addr2", rom_addr_o, 32'h0);
        chk("rs.busy", {31'd0, busy_o}, 32'd0);
        next_cycle();
        rom_ack_i = 1'b1;
        @(negedge clk);
        chk("rs.stale", {31'd0, id_valid_o}, 32'd0);
        chk("rs.busy2", {31'd0, busy_o}, 32'd0);
        next_cycle();
        @(negedge clk);
        next_cycle();
        @(negedge clk);
        chk_head("rs.h0", 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
